// File: rtl/dict_pkg.sv
// Shared definitions for the dictionary lookup arbiter: default widths and
// the controller state encoding.
package dict_pkg;

   localparam int KEY_WIDTH_DEF = 4;
   localparam int VAL_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2
   } dictState_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic. Purely combinational; the caller owns the
// last-grant register. i_lastGrant names the requester that won most
// recently, so on a tie the other requester is granted.
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_lastGrant,
   output logic [1:0] o_gnt
);

   // Pick a one-hot winner; a lone requester always wins immediately
   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = i_lastGrant ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/dict_arbiter.sv
// Dictionary lookup arbiter: a register-array dictionary is streamed in
// entry by entry, after which two requesters share a single lookup port
// through a round-robin arbiter. Each grant produces a registered response
// one cycle later. Loading and lookups live in different controller states,
// so the array never sees a write and a read in the same cycle.
module dict_arbiter
   import dict_pkg::*;
#(
   parameter int KEY_WIDTH = KEY_WIDTH_DEF,
   parameter int VAL_WIDTH = VAL_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_valid,
   input  logic [VAL_WIDTH-1:0] load_data,
   output logic                 load_ready,
   input  logic                 reload,
   output logic                 dict_ready,
   input  logic [1:0]           req_valid,
   input  logic [KEY_WIDTH-1:0] req_key0,
   input  logic [KEY_WIDTH-1:0] req_key1,
   output logic [1:0]           req_ready,
   output logic                 rsp_valid,
   output logic                 rsp_id,
   output logic [VAL_WIDTH-1:0] rsp_val
);

   localparam int DEPTH = 2 ** KEY_WIDTH;
   localparam logic [KEY_WIDTH-1:0] LAST_IDX = '1;

   dictState_t           r_state;
   dictState_t           w_nextState;
   logic [KEY_WIDTH-1:0] r_loadIdx;
   logic [VAL_WIDTH-1:0] r_dict [DEPTH];
   logic                 r_lastGrant;
   logic                 r_rspValid;
   logic                 r_rspId;
   logic [VAL_WIDTH-1:0] r_rspVal;
   logic                 w_loadAccept;
   logic                 w_lookupEn;
   logic [1:0]           w_arbGnt;
   logic [1:0]           w_grant;
   logic [KEY_WIDTH-1:0] w_grantKey;

   rr_arb2 u_arb (
      .i_req       (req_valid),
      .i_lastGrant (r_lastGrant),
      .o_gnt       (w_arbGnt)
   );

   assign w_loadAccept = load_ready & load_valid;
   assign w_grant      = w_lookupEn ? w_arbGnt : 2'b00;
   assign w_grantKey   = w_grant[1] ? req_key1 : req_key0;
   assign req_ready    = w_grant;
   assign rsp_valid    = r_rspValid;
   assign rsp_id       = r_rspId;
   assign rsp_val      = r_rspVal;

   // Controller state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: leave EMPTY at once, finish LOAD on the last entry, reload restarts LOAD
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         EMPTY: w_nextState = LOAD;
         LOAD: begin
            if (!reload && w_loadAccept && (r_loadIdx == LAST_IDX)) begin
               w_nextState = READY;
            end
         end
         READY: begin
            if (reload) begin
               w_nextState = LOAD;
            end
         end
         default: w_nextState = EMPTY;
      endcase
   end

   // State-decoded outputs; a reload pulse blocks both loading and lookups
   always_comb begin
      load_ready = 1'b0;
      dict_ready = 1'b0;
      w_lookupEn = 1'b0;
      case (r_state)
         LOAD: load_ready = ~reload;
         READY: begin
            dict_ready = 1'b1;
            w_lookupEn = ~reload;
         end
         default: begin
            load_ready = 1'b0;
         end
      endcase
   end

   // Load index walks the array in ascending order and wraps after the last entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_loadIdx <= '0;
      end else if (reload) begin
         r_loadIdx <= '0;
      end else if (w_loadAccept) begin
         r_loadIdx <= r_loadIdx + 1'b1;
      end
   end

   // Dictionary storage is deliberately left unreset; a full load always precedes use
   always_ff @(posedge clk) begin
      if (w_loadAccept) begin
         r_dict[r_loadIdx] <= load_data;
      end
   end

   // Remember which requester won last so ties alternate; starts so requester 0 wins first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lastGrant <= 1'b1;
      end else if (|w_grant) begin
         r_lastGrant <= w_grant[1];
      end
   end

   // Register the response at the grant edge; value holds between responses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rspValid <= 1'b0;
         r_rspId    <= 1'b0;
         r_rspVal   <= '0;
      end else begin
         r_rspValid <= |w_grant;
         if (|w_grant) begin
            r_rspId  <= w_grant[1];
            r_rspVal <= r_dict[w_grantKey];
         end
      end
   end

endmodule

// File: tb/tb_dict_arbiter.sv
// Testbench for dict_arbiter: directed scenarios followed by random traffic,
// with responses checked out of an expectation queue by a separate monitor.
module tb_dict_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_ready;
   logic       reload;
   logic       dict_ready;
   logic [1:0] req_valid;
   logic [3:0] req_key0;
   logic [3:0] req_key1;
   logic [1:0] req_ready;
   logic       rsp_valid;
   logic       rsp_id;
   logic [7:0] rsp_val;

   typedef struct {
      logic       id;
      logic [7:0] val;
      int         due;
   } rsp_t;

   rsp_t       expQ[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;

   // Behavioural picture of the dictionary: contents, load progress, tie-break owner
   logic [7:0] modelDict [16];
   bit         modelActive = 1'b0;
   bit         modelLoaded = 1'b0;
   int         modelIdx = 0;
   int         lastWinner = 1;
   logic [7:0] holdVal = 8'h00;

   dict_arbiter #(.KEY_WIDTH(4), .VAL_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .reload     (reload),
      .dict_ready (dict_ready),
      .req_valid  (req_valid),
      .req_key0   (req_key0),
      .req_key1   (req_key1),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_val    (rsp_val)
   );

   always #5 clk = ~clk;

   // Cycle stamp used to schedule when each response is due
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one cycle of inputs, check the combinational outputs, advance the model
   task automatic applyStimulus(input logic lv, input logic [7:0] ld, input logic rl,
                                input logic [1:0] rv, input logic [3:0] k0, input logic [3:0] k1);
      logic       expLr;
      logic [1:0] expGnt;
      int         id;
      rsp_t       r;
      load_valid = lv;
      load_data  = ld;
      reload     = rl;
      req_valid  = rv;
      req_key0   = k0;
      req_key1   = k1;
      @(negedge clk);
      expLr  = modelActive && !modelLoaded && !rl;
      expGnt = 2'b00;
      if (modelLoaded && !rl) begin
         if (rv == 2'b11) expGnt = (lastWinner == 0) ? 2'b10 : 2'b01;
         else             expGnt = rv;
      end
      checkOutput("loadReady", load_ready, expLr);
      checkOutput("dictReady", dict_ready, modelLoaded);
      checkOutput("reqReady", req_ready, expGnt);
      if (expGnt != 2'b00) begin
         id    = expGnt[1] ? 1 : 0;
         r.id  = id[0];
         r.val = modelDict[(id == 1) ? k1 : k0];
         r.due = cyc + 1;
         expQ.push_back(r);
         lastWinner = id;
      end
      if (rl) begin
         modelIdx    = 0;
         modelLoaded = 1'b0;
      end else if (expLr && lv) begin
         modelDict[modelIdx] = ld;
         modelIdx++;
         if (modelIdx == 16) begin
            modelLoaded = 1'b1;
            modelIdx    = 0;
         end
      end
      modelActive = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Assert reset between clock edges and confirm outputs clear without a clock
   task automatic doReset();
      #2 rst = 1'b1;
      #1;
      checkOutput("rstLoadReady", load_ready, 0);
      checkOutput("rstDictReady", dict_ready, 0);
      checkOutput("rstReqReady", req_ready, 0);
      checkOutput("rstRspValid", rsp_valid, 0);
      checkOutput("rstRspId", rsp_id, 0);
      checkOutput("rstRspVal", rsp_val, 0);
      expQ.delete();
      holdVal     = 8'h00;
      modelActive = 1'b0;
      modelLoaded = 1'b0;
      modelIdx    = 0;
      lastWinner  = 1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Stream a whole dictionary: 0 = 8'h10+i, 1 = random words, 2 = gated valid with requests pending
   task automatic loadAll(input int mode);
      int guard = 0;
      bit tog   = 1'b0;
      while (!modelLoaded && guard < 100) begin
         case (mode)
            0: applyStimulus(1'b1, 8'h10 + 8'(modelIdx), 1'b0, 2'b00, 4'h0, 4'h0);
            1: applyStimulus(1'b1, 8'($urandom), 1'b0, 2'($urandom), 4'($urandom), 4'($urandom));
            default: begin
               applyStimulus(tog, 8'($urandom), 1'b0, 2'b11, 4'($urandom), 4'($urandom));
               tog = ~tog;
            end
         endcase
         guard++;
      end
      checkOutput("loadComplete", modelLoaded, 1);
   endtask

   // Read back every entry, alternating requesters
   task automatic sweepKeys();
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b0, 8'h00, 1'b0, (k % 2 == 1) ? 2'b10 : 2'b01, 4'(k), 4'(k));
      end
   endtask

   // Response monitor: a due entry must appear exactly then; otherwise idle and holding
   always @(negedge clk) begin
      if (!rst) begin
         if (expQ.size() > 0 && expQ[0].due == cyc) begin
            checkOutput("rspValid", rsp_valid, 1);
            checkOutput("rspId", rsp_id, expQ[0].id);
            checkOutput("rspVal", rsp_val, expQ[0].val);
            holdVal = expQ[0].val;
            void'(expQ.pop_front());
         end else begin
            checkOutput("rspIdle", rsp_valid, 0);
            checkOutput("rspHold", rsp_val, holdVal);
         end
      end
   end

   initial begin
      rst        = 1'b0;
      load_valid = 1'b0;
      load_data  = 8'h00;
      reload     = 1'b0;
      req_valid  = 2'b00;
      req_key0   = 4'h0;
      req_key1   = 4'h0;
      #1;
      doReset();

      // Scenario 1: plain load, then load_valid ignored once ready
      loadAll(0);
      applyStimulus(1'b1, 8'hEE, 1'b0, 2'b00, 4'h0, 4'h0);

      // Scenario 2: single lookup of key 5
      applyStimulus(1'b0, 8'h00, 1'b0, 2'b01, 4'h5, 4'h0);
      checkOutput("key5Entry", modelDict[5], 8'h15);

      // Scenario 3: contention on keys 2 and A
      repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 2'b11, 4'h2, 4'hA);
      applyStimulus(1'b0, 8'h00, 1'b0, 2'b00, 4'h0, 4'h0);

      // Scenario 4: reload right after a grant, new contents, look up key 0
      applyStimulus(1'b0, 8'h00, 1'b0, 2'b01, 4'h3, 4'h0);
      applyStimulus(1'b1, 8'h55, 1'b1, 2'b11, 4'h1, 4'h2);
      loadAll(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 2'b10, 4'h0, 4'h0);

      // Scenario 5: gated load with requests held during LOAD
      applyStimulus(1'b0, 8'h00, 1'b1, 2'b00, 4'h0, 4'h0);
      loadAll(2);
      sweepKeys();

      // Scenario 6: reset partway through a load, then a full reload
      applyStimulus(1'b0, 8'h00, 1'b1, 2'b00, 4'h0, 4'h0);
      while (modelIdx < 7) applyStimulus(1'b1, 8'($urandom), 1'b0, 2'b00, 4'h0, 4'h0);
      doReset();
      loadAll(1);
      sweepKeys();

      // Reset while a response is on the outputs
      applyStimulus(1'b0, 8'h00, 1'b0, 2'b11, 4'h7, 4'h8);
      doReset();
      loadAll(1);

      // Random traffic with occasional reloads
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom), 8'($urandom), ($urandom_range(0, 39) == 0),
                       2'($urandom), 4'($urandom), 4'($urandom));
      end

      applyStimulus(1'b0, 8'h00, 1'b0, 2'b00, 4'h0, 4'h0);
      applyStimulus(1'b0, 8'h00, 1'b0, 2'b00, 4'h0, 4'h0);
      checkOutput("queueDrained", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
